// File: rtl/renode_axi_burst_manager.sv
`default_nettype none
// renode_axi_burst_manager - single-ID AXI4 INCR burst manager with command, beat-stream and response ports.
// Optional WRAP bursts when RENODE_AXI_WRAP_BURST_EN is defined. Rev 1.0
module renode_axi_burst_manager #(
  parameter int AddressWidth       = 32,
  parameter int DataWidth          = 32,
  parameter int TransactionIdWidth = 8,
  parameter int MaxBurstLen        = 16,
  localparam int StrobeWidth       = DataWidth / 8,
  localparam int LenWidth          = (MaxBurstLen > 1) ? $clog2(MaxBurstLen) : 1
) (
  input  logic                          aclk,
  input  logic                          areset_n,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic                          cmd_write,
  input  logic [AddressWidth-1:0]       cmd_addr,
  input  logic [LenWidth-1:0]           cmd_len,
  input  logic [2:0]                    cmd_size,
  input  logic                          cmd_wrap,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  input  logic [DataWidth-1:0]          wr_data,
  input  logic [StrobeWidth-1:0]        wr_strb,
  output logic                          rd_valid,
  input  logic                          rd_ready,
  output logic [DataWidth-1:0]          rd_data,
  output logic                          rd_last,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic                          rsp_error,
  output logic [TransactionIdWidth-1:0] awid,
  output logic [AddressWidth-1:0]       awaddr,
  output logic [7:0]                    awlen,
  output logic [2:0]                    awsize,
  output logic [1:0]                    awburst,
  output logic                          awlock,
  output logic [3:0]                    awcache,
  output logic [2:0]                    awprot,
  output logic [3:0]                    awqos,
  output logic                          awvalid,
  input  logic                          awready,
  output logic [DataWidth-1:0]          wdata,
  output logic [StrobeWidth-1:0]        wstrb,
  output logic                          wlast,
  output logic                          wvalid,
  input  logic                          wready,
  input  logic [TransactionIdWidth-1:0] bid,
  input  logic [1:0]                    bresp,
  input  logic                          bvalid,
  output logic                          bready,
  output logic [TransactionIdWidth-1:0] arid,
  output logic [AddressWidth-1:0]       araddr,
  output logic [7:0]                    arlen,
  output logic [2:0]                    arsize,
  output logic [1:0]                    arburst,
  output logic                          arlock,
  output logic [3:0]                    arcache,
  output logic [2:0]                    arprot,
  output logic [3:0]                    arqos,
  output logic                          arvalid,
  input  logic                          arready,
  input  logic [TransactionIdWidth-1:0] rid,
  input  logic [DataWidth-1:0]          rdata,
  input  logic [1:0]                    rresp,
  input  logic                          rlast,
  input  logic                          rvalid,
  output logic                          rready
);

  typedef enum logic [1:0] {IDLE, ADDR_DATA, RESP, REJECT} state_t;

  state_t                        state_q, state_d;
  logic                          started_q, started_d;
  logic                          write_q, write_d;
  logic [AddressWidth-1:0]       addr_q, addr_d;
  logic [LenWidth-1:0]           len_q, len_d;
  logic [LenWidth-1:0]           beat_q, beat_d;
  logic [2:0]                    size_q, size_d;
  logic [1:0]                    burst_q, burst_d;
  logic [TransactionIdWidth-1:0] id_q, id_d;
  logic                          awvalid_q, awvalid_d;
  logic                          arvalid_q, arvalid_d;
  logic                          aw_done_q, aw_done_d;
  logic                          w_done_q, w_done_d;
  logic                          rsp_valid_q, rsp_valid_d;
  logic                          err_q, err_d;

  logic [31:0] beat_bytes, len_plus1, end_off;
  logic        cmd_err, in_data;
  logic [7:0]  axlen_w;

  always_comb begin
    beat_bytes = 32'd1 << cmd_size;
    len_plus1  = 32'(cmd_len) + 32'd1;
    end_off    = 32'(cmd_addr[11:0]) + (len_plus1 << cmd_size);
    cmd_err    = 1'b0;
    if (beat_bytes > 32'(StrobeWidth)) cmd_err = 1'b1;
    if ((32'(cmd_addr) & (beat_bytes - 32'd1)) != 32'd0) cmd_err = 1'b1;
    if (len_plus1 > 32'(MaxBurstLen)) cmd_err = 1'b1;
`ifdef RENODE_AXI_WRAP_BURST_EN
    // WRAP bursts stay inside their own wrap window, so the 4 KB rule does not apply
    if (cmd_wrap) begin
      if (!(len_plus1 inside {32'd2, 32'd4, 32'd8, 32'd16})) cmd_err = 1'b1;
    end else if (end_off > 32'd4096) begin
      cmd_err = 1'b1;
    end
`else
    if (cmd_wrap) cmd_err = 1'b1;
    if (end_off > 32'd4096) cmd_err = 1'b1;
`endif
  end

  always_comb begin
    state_d     = state_q;
    started_d   = 1'b1;
    write_d     = write_q;
    addr_d      = addr_q;
    len_d       = len_q;
    size_d      = size_q;
    burst_d     = burst_q;
    beat_d      = beat_q;
    id_d        = id_q;
    awvalid_d   = awvalid_q;
    arvalid_d   = arvalid_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    rsp_valid_d = rsp_valid_q;
    err_d       = err_q;

    in_data   = (state_q == ADDR_DATA);
    cmd_ready = started_q && (state_q == IDLE);
    wvalid    = in_data && write_q && !w_done_q && wr_valid;
    wr_ready  = in_data && write_q && !w_done_q && wready;
    wlast     = in_data && write_q && !w_done_q && (beat_q == len_q);
    rd_valid  = in_data && !write_q && rvalid;
    rready    = in_data && !write_q && rd_ready;
    rd_last   = in_data && !write_q && (beat_q == len_q);
    bready    = (state_q == RESP) && write_q && !rsp_valid_q;

    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          if (cmd_err) begin
            state_d     = REJECT;
            rsp_valid_d = 1'b1;
            err_d       = 1'b1;
          end else begin
            state_d   = ADDR_DATA;
            write_d   = cmd_write;
            addr_d    = cmd_addr;
            len_d     = cmd_len;
            size_d    = cmd_size;
`ifdef RENODE_AXI_WRAP_BURST_EN
            burst_d   = cmd_wrap ? 2'b10 : 2'b01;
`else
            burst_d   = 2'b01;
`endif
            beat_d    = '0;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
            awvalid_d = cmd_write;
            arvalid_d = !cmd_write;
            err_d     = 1'b0;
          end
        end
      end
      ADDR_DATA: begin
        if (awvalid_q && awready) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (arvalid_q && arready) arvalid_d = 1'b0;
        if (write_q) begin
          if (wvalid && wready) begin
            beat_d = beat_q + LenWidth'(1);
            if (wlast) w_done_d = 1'b1;
          end
          // W may finish before AW; the response phase waits for both
          if (aw_done_d && w_done_d) state_d = RESP;
        end else if (rvalid && rready) begin
          beat_d = beat_q + LenWidth'(1);
          if (rresp[1] || (rid != id_q) || (rlast != rd_last)) err_d = 1'b1;
          if (rlast || rd_last) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
          end
        end
      end
      RESP: begin
        if (bvalid && bready) begin
          rsp_valid_d = 1'b1;
          if (bresp[1] || (bid != id_q)) err_d = 1'b1;
        end
        if (rsp_valid_q && rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          err_d       = 1'b0;
          id_d        = id_q + TransactionIdWidth'(1);
        end
      end
      REJECT: begin
        if (rsp_valid_q && rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          err_d       = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      started_q   <= 1'b0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      len_q       <= '0;
      size_q      <= '0;
      burst_q     <= 2'b01;
      beat_q      <= '0;
      id_q        <= '0;
      awvalid_q   <= 1'b0;
      arvalid_q   <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      started_q   <= started_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      size_q      <= size_d;
      burst_q     <= burst_d;
      beat_q      <= beat_d;
      id_q        <= id_d;
      awvalid_q   <= awvalid_d;
      arvalid_q   <= arvalid_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      rsp_valid_q <= rsp_valid_d;
      err_q       <= err_d;
    end
  end

  assign axlen_w   = 8'(len_q);
  assign awid      = id_q;
  assign awaddr    = addr_q;
  assign awlen     = axlen_w;
  assign awsize    = size_q;
  assign awburst   = burst_q;
  assign awlock    = 1'b0;
  assign awcache   = 4'd0;
  assign awprot    = 3'd0;
  assign awqos     = 4'd0;
  assign awvalid   = awvalid_q;
  assign wdata     = wr_data;
  assign wstrb     = wr_strb;
  assign arid      = id_q;
  assign araddr    = addr_q;
  assign arlen     = axlen_w;
  assign arsize    = size_q;
  assign arburst   = burst_q;
  assign arlock    = 1'b0;
  assign arcache   = 4'd0;
  assign arprot    = 3'd0;
  assign arqos     = 4'd0;
  assign arvalid   = arvalid_q;
  assign rd_data   = rdata;
  assign rsp_valid = rsp_valid_q;
  assign rsp_error = err_q;

endmodule
`default_nettype wire

// File: tb/tb_renode_axi_burst_manager.sv
`default_nettype none
// Bench for renode_axi_burst_manager: directed table, reset corner case, randomized commands vs. model.
module tb_renode_axi_burst_manager;

  logic        aclk = 1'b0;
  logic        areset_n;
  logic        cmd_valid, cmd_ready, cmd_write, cmd_wrap;
  logic [31:0] cmd_addr;
  logic [3:0]  cmd_len;
  logic [2:0]  cmd_size;
  logic        wr_valid, wr_ready;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;
  logic        rd_valid, rd_ready, rd_last;
  logic [31:0] rd_data;
  logic        rsp_valid, rsp_ready, rsp_error;
  logic [7:0]  awid, arid, bid, rid;
  logic [31:0] awaddr, araddr, wdata, rdata;
  logic [7:0]  awlen, arlen;
  logic [2:0]  awsize, arsize, awprot, arprot;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic        awlock, arlock, awvalid, awready, arvalid, arready;
  logic [3:0]  awcache, arcache, awqos, arqos, wstrb;
  logic        wlast, wvalid, wready, bvalid, bready, rlast, rvalid, rready;

  int checks = 0;
  int failures = 0;
  int txn_no = 0;
  logic [7:0] model_id = 8'd0;

  always #5 aclk = ~aclk;

  renode_axi_burst_manager dut (
    .aclk(aclk), .areset_n(areset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write), .cmd_addr(cmd_addr),
    .cmd_len(cmd_len), .cmd_size(cmd_size), .cmd_wrap(cmd_wrap),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_strb(wr_strb),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_error(rsp_error),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awqos(awqos),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arqos(arqos),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  // rlast_mode: 0 = correct rlast, 1 = rlast one beat early, 2 = rlast never sent
  typedef struct {
    bit          wr;
    logic [31:0] addr;
    int          len;
    int          size;
    bit          wrap;
    int          err_beat;
    int          id_off;
    int          rlast_mode;
    int          aw_delay;
    bit          rbp;
    bit          exp_rej;
    bit          exp_err;
  } vec_t;

  vec_t tbl[16];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (txn %0d, t=%0t)", name, act, exp, txn_no, $time);
    end
  endtask

  function automatic logic [31:0] pat(input int b);
    return {8'hC3, 8'(txn_no), 16'(b)};
  endfunction

  function automatic bit model_reject(input bit wrap, input longint addr, input int len, input int size);
    longint bytes;
    bytes = longint'(1) << size;
    if (wrap) return 1'b1;
    if (bytes > 4) return 1'b1;
    if ((addr % bytes) != 0) return 1'b1;
    if (len + 1 > 16) return 1'b1;
    if ((addr % 4096) + longint'(len + 1) * bytes > 4096) return 1'b1;
    return 1'b0;
  endfunction

  task automatic idle_inputs();
    cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_len = 0; cmd_size = 0; cmd_wrap = 0;
    wr_valid = 0; wr_data = 0; wr_strb = 0; rd_ready = 0; rsp_ready = 0;
    awready = 0; wready = 0; bid = 0; bresp = 0; bvalid = 0;
    arready = 0; rid = 0; rdata = 0; rresp = 0; rlast = 0; rvalid = 0;
  endtask

  // Leaves the caller at posedge+1 of the cycle following the accepting edge.
  task automatic send_cmd(input bit wr, input logic [31:0] addr, input int len, input int size, input bit wrap);
    int t;
    t = 0;
    cmd_valid = 1; cmd_write = wr; cmd_addr = addr; cmd_len = 4'(len); cmd_size = 3'(size); cmd_wrap = wrap;
    #1;
    while (!cmd_ready && t < 50) begin
      @(posedge aclk); #1;
      t++;
    end
    if (!cmd_ready) chk("cmd_ready_timeout", 0, 1);
    @(posedge aclk); #1;
    cmd_valid = 0;
  endtask

  task automatic run_txn(input vec_t v);
    int cyc, w_cnt, r_cnt, b_cnt, n_sub, n_exp;
    bit done, ar_done, aw_done, any_bus;
    logic [7:0] exp_id;
    cyc = 0; w_cnt = 0; r_cnt = 0; b_cnt = 0;
    done = 0; ar_done = 0; aw_done = 0; any_bus = 0;
    exp_id = model_id;
    txn_no++;
    n_sub = (v.rlast_mode == 1) ? v.len : v.len + 1;
    n_exp = n_sub;
    send_cmd(v.wr, v.addr, v.len, v.size, v.wrap);
    while (!done && cyc < 400) begin
      awready   = (cyc >= v.aw_delay);
      arready   = (cyc >= v.aw_delay);
      wr_valid  = (w_cnt <= v.len) && (!v.rbp || $urandom_range(0, 1) == 1);
      wr_data   = pat(w_cnt);
      wr_strb   = 4'hF ^ 4'(w_cnt);
      wready    = !v.rbp || $urandom_range(0, 1) == 1;
      rvalid    = !v.wr && ar_done && (r_cnt < n_sub);
      rdata     = pat(r_cnt);
      rresp     = (r_cnt == v.err_beat) ? 2'b10 : 2'b00;
      rid       = exp_id + 8'(v.id_off);
      rlast     = (v.rlast_mode == 0) ? (r_cnt == v.len) : (v.rlast_mode == 1) ? (r_cnt == v.len - 1) : 1'b0;
      rd_ready  = !v.rbp || $urandom_range(0, 1) == 1;
      bvalid    = v.wr && aw_done && (w_cnt > v.len) && (b_cnt == 0);
      bid       = exp_id + 8'(v.id_off);
      bresp     = (v.err_beat >= 0) ? 2'b10 : 2'b00;
      rsp_ready = !v.rbp || $urandom_range(0, 1) == 1;
      #1;
      any_bus |= awvalid | arvalid | wvalid | rready | bready;
      if (cyc == 0) begin
        if (v.exp_rej) chk("reject_rsp_next_cycle", rsp_valid, 1);
        else chk("axvalid_after_accept", v.wr ? awvalid : arvalid, 1);
      end
      if (awvalid && awready) begin
        aw_done = 1;
        chk("awaddr", awaddr, v.addr);
        chk("awlen", awlen, v.len);
        chk("awsize", awsize, v.size);
        chk("awburst", awburst, 1);
        chk("awid", awid, exp_id);
        chk("awlock_prot", {awlock, awprot}, 0);
      end
      if (arvalid && arready) begin
        ar_done = 1;
        chk("araddr", araddr, v.addr);
        chk("arlen", arlen, v.len);
        chk("arsize", arsize, v.size);
        chk("arburst", arburst, 1);
        chk("arid", arid, exp_id);
        chk("arlock_prot", {arlock, arprot}, 0);
      end
      if (wvalid && wready) begin
        chk("wr_ready", wr_ready, 1);
        chk("wdata", wdata, pat(w_cnt));
        chk("wstrb", wstrb, 4'hF ^ 4'(w_cnt));
        chk("wlast", wlast, (w_cnt == v.len));
        w_cnt++;
      end
      if (rvalid && rready) begin
        chk("rd_valid", rd_valid, 1);
        chk("rd_data", rd_data, pat(r_cnt));
        chk("rd_last", rd_last, (r_cnt == v.len));
        r_cnt++;
      end
      if (bvalid && bready) b_cnt++;
      if (rsp_valid && rsp_ready) begin
        chk("rsp_error", rsp_error, v.exp_err);
        done = 1;
      end
      @(posedge aclk); #1;
      cyc++;
    end
    idle_inputs();
    if (!done) chk("rsp_timeout", 0, 1);
    if (v.exp_rej) begin
      chk("reject_no_bus_activity", any_bus, 0);
    end else if (v.wr) begin
      chk("w_beats", w_cnt, v.len + 1);
      chk("b_count", b_cnt, 1);
      model_id = model_id + 8'd1;
    end else begin
      chk("r_beats", r_cnt, n_exp);
      model_id = model_id + 8'd1;
    end
  endtask

  task automatic reset_mid_read();
    txn_no++;
    send_cmd(1'b0, 32'h100, 3, 2, 1'b0);
    arready = 1;
    #1 chk("rst_seq_arvalid", arvalid, 1);
    @(posedge aclk); #1;
    arready = 0; rvalid = 1; rdata = pat(0); rid = model_id; rresp = 0; rlast = 0; rd_ready = 1;
    @(posedge aclk); #1;
    rdata = pat(1);
    #1 chk("rst_seq_beat2_offered", rd_valid, 1);
    #1 areset_n = 0;
    #1;
    chk("rst_async_valids", {arvalid, awvalid, wvalid, rd_valid, rready, rsp_valid, bready}, 0);
    chk("rst_async_cmd_ready", cmd_ready, 0);
    chk("rst_async_axlen_axaddr", {arlen, araddr, rsp_error}, 0);
    rvalid = 0; rd_ready = 0;
    @(posedge aclk); #1;
    areset_n = 1;
    #1 chk("rst_release_cmd_ready_low", cmd_ready, 0);
    @(posedge aclk); #1;
    chk("rst_release_cmd_ready_high", cmd_ready, 1);
    model_id = 8'd0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t rv;
    idle_inputs();
    areset_n = 0;
    //          wr    addr          len sz wrap ebeat idoff rl awd rbp rej err
    tbl[0]  = '{1'b0, 32'h0000_0100, 3, 2, 1'b0, -1, 0, 0, 0,  1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 32'h0000_0040, 7, 2, 1'b0, -1, 0, 0, 12, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 32'h0000_0FF8, 3, 2, 1'b0, -1, 0, 0, 0,  1'b0, 1'b1, 1'b1};
    tbl[3]  = '{1'b0, 32'h0000_0200, 3, 2, 1'b0,  1, 0, 0, 0,  1'b0, 1'b0, 1'b1};
    tbl[4]  = '{1'b1, 32'h0000_0300, 1, 2, 1'b0, -1, 1, 0, 0,  1'b0, 1'b0, 1'b1};
    tbl[5]  = '{1'b0, 32'h0000_0400, 0, 2, 1'b0, -1, 0, 0, 0,  1'b0, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 32'h0000_0102, 0, 2, 1'b0, -1, 0, 0, 0,  1'b0, 1'b1, 1'b1};
    tbl[7]  = '{1'b1, 32'h0000_0000, 0, 3, 1'b0, -1, 0, 0, 0,  1'b0, 1'b1, 1'b1};
    tbl[8]  = '{1'b0, 32'h0000_0500, 2, 2, 1'b1, -1, 0, 0, 0,  1'b0, 1'b1, 1'b1};
    tbl[9]  = '{1'b0, 32'h0000_0600, 3, 2, 1'b0, -1, 0, 1, 0,  1'b0, 1'b0, 1'b1};
    tbl[10] = '{1'b0, 32'h0000_0700, 3, 2, 1'b0, -1, 0, 2, 0,  1'b0, 1'b0, 1'b1};
    tbl[11] = '{1'b1, 32'h0000_1FC0, 15, 2, 1'b0, -1, 0, 0, 2, 1'b0, 1'b0, 1'b0};
    tbl[12] = '{1'b1, 32'h0000_0800, 2, 1, 1'b0, -1, 0, 0, 1,  1'b1, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 32'h0000_0FFC, 0, 2, 1'b0, -1, 0, 0, 0,  1'b0, 1'b0, 1'b0};
    tbl[14] = '{1'b0, 32'h0000_0900, 5, 0, 1'b0, -1, 1, 0, 0,  1'b1, 1'b0, 1'b1};
    tbl[15] = '{1'b1, 32'h0000_0A00, 3, 2, 1'b0,  0, 0, 0, 3,  1'b1, 1'b0, 1'b1};

    repeat (2) @(posedge aclk);
    #1;
    chk("reset_valids", {awvalid, arvalid, wvalid, rd_valid, rsp_valid}, 0);
    chk("reset_readies", {cmd_ready, wr_ready, rready, bready}, 0);
    chk("reset_rsp_error", rsp_error, 0);
    chk("reset_axlen", {awlen, arlen}, 0);
    chk("reset_axaddr", {awaddr, araddr}, 0);
    areset_n = 1;
    #1 chk("cmd_ready_low_at_release", cmd_ready, 0);
    @(posedge aclk); #1;
    chk("cmd_ready_one_cycle_after_release", cmd_ready, 1);

    for (int i = 0; i < 16; i++) run_txn(tbl[i]);

    reset_mid_read();
    run_txn(tbl[0]);

    for (int i = 0; i < 40; i++) begin
      rv.wr   = $urandom_range(0, 1) == 1;
      rv.size = $urandom_range(0, 3);
      rv.len  = $urandom_range(0, 15);
      rv.addr = 32'($urandom_range(0, 15)) << 12;
      rv.addr = rv.addr + (($urandom_range(0, 1) == 1) ? 32'($urandom_range(12'hF00, 12'hFFF))
                                                       : 32'($urandom_range(0, 12'hEFF)));
      if ($urandom_range(0, 3) != 0) rv.addr = rv.addr & ~((32'd1 << rv.size) - 32'd1);
      rv.wrap       = $urandom_range(0, 9) == 0;
      rv.err_beat   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, rv.len)) : -1;
      rv.id_off     = ($urandom_range(0, 7) == 0) ? 1 : 0;
      rv.rlast_mode = 0;
      rv.aw_delay   = $urandom_range(0, 4);
      rv.rbp        = $urandom_range(0, 1) == 1;
      rv.exp_rej    = model_reject(rv.wrap, longint'(rv.addr), rv.len, rv.size);
      rv.exp_err    = rv.exp_rej || (rv.err_beat >= 0) || (rv.id_off != 0);
      run_txn(rv);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
